frame_header_parser: RTL and testbench
======================================

FRAME_HEADER_PARSER -- requirements
Module: frame_header_parser

Interface
REQ-001 SHALL have parameter FIFO_ADDR_SIZE, default 10, meaning the byte-address/length width shared with the upstream frame buffer.
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port fifo_ready, input, 1, meaning the upstream buffer holds a complete frame.
REQ-005 SHALL have port fifo_data_len, input, FIFO_ADDR_SIZE, meaning frame length in bytes.
REQ-006 SHALL have port fifo_data, input, 32, meaning the big-endian word at the byte offset read_ptr; bits [31:24] hold byte read_ptr.
REQ-007 SHALL have port read_ptr, output, FIFO_ADDR_SIZE, meaning the registered byte offset requested from the buffer.
REQ-008 SHALL have port flush, output, 1, a one-cycle pulse that releases the frame in the buffer.
REQ-009 SHALL have ports hdr_valid (output, 1) and hdr_ready (input, 1), meaning header-result handshake.
REQ-010 SHALL have outputs dst_mac (48), src_mac (48), ethertype (16), is_ipv4 (1), ip_proto (8), src_ip (32), dst_ip (32) and frame_len (FIFO_ADDR_SIZE), meaning parsed header fields.
REQ-011 SHALL have port drop_count, output, 16, meaning the number of runt frames discarded.

Function
REQ-012 SHALL implement states IDLE, RD_ISSUE, RD_CAPTURE, OUTPUT and FLUSH.
REQ-013 SHALL treat fifo_data as valid one cycle after read_ptr changes: RD_ISSUE presents the address, and RD_CAPTURE samples the data on its ending edge, so each word costs 2 cycles.
REQ-014 In IDLE with fifo_ready=1 and fifo_data_len>=14, SHALL latch frame_len=fifo_data_len, set read_ptr=0 and enter RD_ISSUE.
REQ-015 In IDLE with fifo_ready=1 and fifo_data_len<14, SHALL go directly to FLUSH, increment drop_count (saturating at 0xFFFF) and never assert hdr_valid.
REQ-016 SHALL read Ethernet words at offsets 0, 4, 8 and 12 as follows:
- dst_mac = {w0, w4[31:16]}
- src_mac = {w4[15:0], w8}
- ethertype = w12[31:16]
REQ-017 After the offset-12 capture, if ethertype==16'h0800 and frame_len>=34, SHALL read offsets 20, 26 and 30 as follows:
- ip_proto = w20[7:0]
- src_ip = w26
- dst_ip = w30
- is_ipv4 = 1
REQ-018 Otherwise, SHALL set is_ipv4=0 and ip_proto, src_ip and dst_ip to 0, and enter OUTPUT.
REQ-019 Counting from the IDLE-exit edge, SHALL assert hdr_valid 8 cycles later for non-IPv4 frames and 14 cycles later for IPv4 frames.
REQ-020 In OUTPUT, SHALL hold hdr_valid=1 and all header fields stable until hdr_ready=1; hdr_ready may be asserted before hdr_valid.
REQ-021 SHALL complete the transfer on the edge where hdr_valid && hdr_ready, then deassert hdr_valid and enter FLUSH.
REQ-022 In FLUSH, SHALL assert flush for exactly one cycle, then return to IDLE.
REQ-023 SHALL ignore fifo_ready in every state except IDLE.
REQ-024 SHALL hold read_ptr at its last value outside RD_ISSUE and RD_CAPTURE.
REQ-025 SHALL compute all offsets as FIFO_ADDR_SIZE-wide constants; no wrap-around occurs because offsets never exceed 30.
REQ-026 SHALL retain header fields after the handshake until they are overwritten by the next frame.

Reset
REQ-027 While areset=1 at a clock edge, SHALL drive the following on the next cycle and enter IDLE:
- state=IDLE
- read_ptr=0, flush=0, hdr_valid=0
- all header fields=0
- frame_len=0, drop_count=0
REQ-028 An areset asserted mid-frame in any state SHALL abort the parse without emitting flush or hdr_valid.

Verification
REQ-029 IPv4 frame, len 60, dst_mac 0x001122334455, src_mac 0x66778899AABB, ethertype 0x0800, proto 0x11, src 10.0.0.1, dst 10.0.0.2, hdr_ready=1 -> hdr_valid 14 cycles after IDLE exit with exactly those fields and is_ipv4=1, then a single flush pulse on the cycle after the handshake.
REQ-030 ARP frame, ethertype 0x0806, len 42 -> hdr_valid 8 cycles after IDLE exit, is_ipv4=0, ip_proto/src_ip/dst_ip=0, frame_len=42.
REQ-031 Runt frame, len 10 -> no hdr_valid, one flush pulse, drop_count 0 -> 1; with drop_count preset to 0xFFFF by 65535 runts, one more runt -> drop_count stays 0xFFFF.
REQ-032 IPv4 ethertype with len 20 -> reported with is_ipv4=0, and no read of offset 20 or higher is ever issued.
REQ-033 hdr_ready held low for 20 cycles after hdr_valid -> all fields stable and flush=0 throughout; hdr_ready=1 -> flush pulses on the following cycle.
REQ-034 areset pulsed during RD_CAPTURE of offset 8 -> all outputs zero, no flush; after reset, with fifo_ready still 1, the full parse restarts from offset 0.

Source files
------------

// File: rtl/frame_header_parser.sv
// Ethernet/IPv4 header extractor: walks a buffered frame one 32-bit word at a time
// and presents the parsed header fields through a valid/ready handshake.
module frame_header_parser #(
  parameter int FIFO_ADDR_SIZE = 10
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      fifo_ready,
  input  logic [FIFO_ADDR_SIZE-1:0] fifo_data_len,
  input  logic [31:0]               fifo_data,
  output logic [FIFO_ADDR_SIZE-1:0] read_ptr,
  output logic                      flush,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic [47:0]               dst_mac,
  output logic [47:0]               src_mac,
  output logic [15:0]               ethertype,
  output logic                      is_ipv4,
  output logic [7:0]                ip_proto,
  output logic [31:0]               src_ip,
  output logic [31:0]               dst_ip,
  output logic [FIFO_ADDR_SIZE-1:0] frame_len,
  output logic [15:0]               drop_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    OUTPUT,
    FLUSH
  } state_t;

  localparam logic [FIFO_ADDR_SIZE-1:0] MIN_FRAME_LEN = FIFO_ADDR_SIZE'(14);
  localparam logic [FIFO_ADDR_SIZE-1:0] IPV4_MIN_LEN  = FIFO_ADDR_SIZE'(34);

  // Byte offset of each header word; indices 4..6 are only reached for IPv4.
  function automatic logic [FIFO_ADDR_SIZE-1:0] word_offset(input logic [2:0] idx);
    logic [FIFO_ADDR_SIZE-1:0] off;
    case (idx)
      3'd0:    off = FIFO_ADDR_SIZE'(0);
      3'd1:    off = FIFO_ADDR_SIZE'(4);
      3'd2:    off = FIFO_ADDR_SIZE'(8);
      3'd3:    off = FIFO_ADDR_SIZE'(12);
      3'd4:    off = FIFO_ADDR_SIZE'(20);
      3'd5:    off = FIFO_ADDR_SIZE'(26);
      3'd6:    off = FIFO_ADDR_SIZE'(30);
      default: off = FIFO_ADDR_SIZE'(0);
    endcase
    return off;
  endfunction

  state_t                      state_q, state_d;
  logic [2:0]                  word_idx_q, word_idx_d;
  logic [FIFO_ADDR_SIZE-1:0]   read_ptr_q, read_ptr_d;
  logic [47:0]                 dst_mac_q, dst_mac_d;
  logic [47:0]                 src_mac_q, src_mac_d;
  logic [15:0]                 ethertype_q, ethertype_d;
  logic                        is_ipv4_q, is_ipv4_d;
  logic [7:0]                  ip_proto_q, ip_proto_d;
  logic [31:0]                 src_ip_q, src_ip_d;
  logic [31:0]                 dst_ip_q, dst_ip_d;
  logic [FIFO_ADDR_SIZE-1:0]   frame_len_q, frame_len_d;
  logic [15:0]                 drop_count_q, drop_count_d;

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    read_ptr_d   = read_ptr_q;
    dst_mac_d    = dst_mac_q;
    src_mac_d    = src_mac_q;
    ethertype_d  = ethertype_q;
    is_ipv4_d    = is_ipv4_q;
    ip_proto_d   = ip_proto_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    frame_len_d  = frame_len_q;
    drop_count_d = drop_count_q;

    case (state_q)
      IDLE: begin
        if (fifo_ready) begin
          if (fifo_data_len >= MIN_FRAME_LEN) begin
            frame_len_d = fifo_data_len;
            read_ptr_d  = '0;
            word_idx_d  = 3'd0;
            state_d     = RD_ISSUE;
          end else begin
            state_d = FLUSH;
            if (drop_count_q != 16'hFFFF) begin
              drop_count_d = drop_count_q + 16'd1;
            end
          end
        end
      end

      RD_ISSUE: state_d = RD_CAPTURE;

      RD_CAPTURE: begin
        state_d    = RD_ISSUE;
        word_idx_d = word_idx_q + 3'd1;
        read_ptr_d = word_offset(word_idx_q + 3'd1);
        case (word_idx_q)
          3'd0: dst_mac_d[47:16] = fifo_data;
          3'd1: begin
            dst_mac_d[15:0]  = fifo_data[31:16];
            src_mac_d[47:32] = fifo_data[15:0];
          end
          3'd2: src_mac_d[31:0] = fifo_data;
          3'd3: begin
            ethertype_d = fifo_data[31:16];
            // Too short to hold an IP header, or not IPv4: finish with the L2 fields only.
            if (!((fifo_data[31:16] == 16'h0800) && (frame_len_q >= IPV4_MIN_LEN))) begin
              is_ipv4_d  = 1'b0;
              ip_proto_d = '0;
              src_ip_d   = '0;
              dst_ip_d   = '0;
              word_idx_d = word_idx_q;
              read_ptr_d = read_ptr_q;
              state_d    = OUTPUT;
            end
          end
          3'd4: ip_proto_d = fifo_data[7:0];
          3'd5: src_ip_d = fifo_data;
          3'd6: begin
            dst_ip_d   = fifo_data;
            is_ipv4_d  = 1'b1;
            word_idx_d = word_idx_q;
            read_ptr_d = read_ptr_q;
            state_d    = OUTPUT;
          end
          default: state_d = IDLE;
        endcase
      end

      OUTPUT: begin
        if (hdr_ready) begin
          state_d = FLUSH;
        end
      end

      FLUSH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      read_ptr_q   <= '0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      ethertype_q  <= '0;
      is_ipv4_q    <= 1'b0;
      ip_proto_q   <= '0;
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      frame_len_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      read_ptr_q   <= read_ptr_d;
      dst_mac_q    <= dst_mac_d;
      src_mac_q    <= src_mac_d;
      ethertype_q  <= ethertype_d;
      is_ipv4_q    <= is_ipv4_d;
      ip_proto_q   <= ip_proto_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      frame_len_q  <= frame_len_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Handshake and flush strobes decode straight from the state register.
  assign hdr_valid  = (state_q == OUTPUT);
  assign flush      = (state_q == FLUSH);
  assign read_ptr   = read_ptr_q;
  assign dst_mac    = dst_mac_q;
  assign src_mac    = src_mac_q;
  assign ethertype  = ethertype_q;
  assign is_ipv4    = is_ipv4_q;
  assign ip_proto   = ip_proto_q;
  assign src_ip     = src_ip_q;
  assign dst_ip     = dst_ip_q;
  assign frame_len  = frame_len_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_frame_header_parser.sv
// Directed bench for frame_header_parser: a byte-array frame buffer with one cycle
// of read latency feeds the parser, and every result is compared to hand-built values.
module tb_frame_header_parser;

  localparam int FA = 10;

  logic          aclk = 1'b0;
  logic          areset;
  logic          fifo_ready;
  logic [FA-1:0] fifo_data_len;
  logic [31:0]   fifo_data;
  logic [FA-1:0] read_ptr;
  logic          flush;
  logic          hdr_valid;
  logic          hdr_ready;
  logic [47:0]   dst_mac;
  logic [47:0]   src_mac;
  logic [15:0]   ethertype;
  logic          is_ipv4;
  logic [7:0]    ip_proto;
  logic [31:0]   src_ip;
  logic [31:0]   dst_ip;
  logic [FA-1:0] frame_len;
  logic [15:0]   drop_count;

  logic [7:0] mem [0:63];
  int total = 0;
  int bad = 0;
  int fl_cnt = 0;
  int hv_cnt = 0;
  int hi_cnt = 0;

  frame_header_parser #(.FIFO_ADDR_SIZE(FA)) dut (
    .aclk(aclk), .areset(areset), .fifo_ready(fifo_ready),
    .fifo_data_len(fifo_data_len), .fifo_data(fifo_data), .read_ptr(read_ptr),
    .flush(flush), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype), .is_ipv4(is_ipv4),
    .ip_proto(ip_proto), .src_ip(src_ip), .dst_ip(dst_ip), .frame_len(frame_len),
    .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  // Buffer model: the word at read_ptr appears one clock after the address.
  always @(posedge aclk) begin
    int p;
    p = int'(read_ptr);
    fifo_data <= {mem[p & 63], mem[(p + 1) & 63], mem[(p + 2) & 63], mem[(p + 3) & 63]};
  end

  // Event counters, sampled per cycle; tests look at differences across a window.
  always @(posedge aclk) begin
    if (flush) fl_cnt <= fl_cnt + 1;
    if (hdr_valid) hv_cnt <= hv_cnt + 1;
    if (read_ptr >= FA'(20)) hi_cnt <= hi_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic buildFrame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                            input logic [7:0] pr, input logic [31:0] si, input logic [31:0] di);
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 6; i++) begin
      mem[i]     = d[47 - 8*i -: 8];
      mem[6 + i] = s[47 - 8*i -: 8];
    end
    mem[12] = et[15:8];
    mem[13] = et[7:0];
    mem[23] = pr;
    for (int i = 0; i < 4; i++) begin
      mem[26 + i] = si[31 - 8*i -: 8];
      mem[30 + i] = di[31 - 8*i -: 8];
    end
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge aclk);
      #1;
      if (hdr_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // Present one frame, release fifo_ready after the IDLE-exit edge, return hdr_valid latency.
  task automatic applyStimulus(input logic [FA-1:0] len, output int lat);
    @(negedge aclk);
    fifo_data_len = len;
    fifo_ready    = 1'b1;
    @(posedge aclk);
    #1;
    fifo_ready = 1'b0;
    waitValid(lat);
  endtask

  task automatic checkHeader(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                             input logic ip4, input logic [7:0] pr, input logic [31:0] si,
                             input logic [31:0] di, input logic [FA-1:0] fl);
    checkOutput("dst_mac", 64'(dst_mac), 64'(d));
    checkOutput("src_mac", 64'(src_mac), 64'(s));
    checkOutput("ethertype", 64'(ethertype), 64'(et));
    checkOutput("is_ipv4", 64'(is_ipv4), 64'(ip4));
    checkOutput("ip_proto", 64'(ip_proto), 64'(pr));
    checkOutput("src_ip", 64'(src_ip), 64'(si));
    checkOutput("dst_ip", 64'(dst_ip), 64'(di));
    checkOutput("frame_len", 64'(frame_len), 64'(fl));
  endtask

  // With hdr_ready already high: handshake on the next edge, then one flush cycle.
  task automatic checkHandshake(input string tag);
    @(posedge aclk);
    #1;
    checkOutput({tag, "_flush_on"}, 64'(flush), 64'd1);
    checkOutput({tag, "_valid_off"}, 64'(hdr_valid), 64'd0);
    @(posedge aclk);
    #1;
    checkOutput({tag, "_flush_off"}, 64'(flush), 64'd0);
  endtask

  task automatic runRunt();
    @(negedge aclk);
    fifo_data_len = FA'(10);
    fifo_ready    = 1'b1;
    @(posedge aclk);
    #1;
    fifo_ready = 1'b0;
    checkOutput("runt_flush", 64'(flush), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int lat;
    int fl0, hv0, hi0;
    logic stable_ok;

    areset = 1'b1;
    fifo_ready = 1'b0;
    fifo_data_len = '0;
    hdr_ready = 1'b0;
    buildFrame(48'h0, 48'h0, 16'h0, 8'h0, 32'h0, 32'h0);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_read_ptr", 64'(read_ptr), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);
    checkOutput("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
    checkHeader(48'h0, 48'h0, 16'h0, 1'b0, 8'h0, 32'h0, 32'h0, FA'(0));
    areset = 1'b0;

    // IPv4, len 60, hdr_ready already high
    buildFrame(48'h001122334455, 48'h66778899AABB, 16'h0800, 8'h11, 32'h0A000001, 32'h0A000002);
    hdr_ready = 1'b1;
    fl0 = fl_cnt;
    applyStimulus(FA'(60), lat);
    checkOutput("ipv4_latency", 64'(lat), 64'd14);
    checkHeader(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b1, 8'h11,
                32'h0A000001, 32'h0A000002, FA'(60));
    checkHandshake("ipv4");
    checkOutput("ipv4_flush_count", 64'(fl_cnt - fl0), 64'd1);
    checkOutput("ipv4_fields_kept", 64'(src_ip), 64'h0A000001);

    // ARP, len 42
    buildFrame(48'hFFFFFFFFFFFF, 48'h020304050607, 16'h0806, 8'h55, 32'h12345678, 32'h9ABCDEF0);
    applyStimulus(FA'(42), lat);
    checkOutput("arp_latency", 64'(lat), 64'd8);
    checkHeader(48'hFFFFFFFFFFFF, 48'h020304050607, 16'h0806, 1'b0, 8'h0, 32'h0, 32'h0, FA'(42));
    checkHandshake("arp");

    // IPv4 ethertype but only 20 bytes: L2 only, never reads offset 20+
    buildFrame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 8'h06, 32'hC0A80001, 32'hC0A80002);
    hi0 = hi_cnt;
    applyStimulus(FA'(20), lat);
    checkOutput("short_ip_latency", 64'(lat), 64'd8);
    checkHeader(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 1'b0, 8'h0, 32'h0, 32'h0, FA'(20));
    checkHandshake("short_ip");
    checkOutput("short_ip_no_high_read", 64'(hi_cnt - hi0), 64'd0);

    // Minimum lengths on both paths: 14 (L2 only) and 34 (full IPv4)
    buildFrame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h86DD, 8'h3A, 32'h1, 32'h2);
    applyStimulus(FA'(14), lat);
    checkOutput("len14_latency", 64'(lat), 64'd8);
    checkHeader(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h86DD, 1'b0, 8'h0, 32'h0, 32'h0, FA'(14));
    checkHandshake("len14");
    buildFrame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 8'h01, 32'hAC100001, 32'hAC1000FE);
    applyStimulus(FA'(34), lat);
    checkOutput("len34_latency", 64'(lat), 64'd14);
    checkHeader(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 1'b1, 8'h01,
                32'hAC100001, 32'hAC1000FE, FA'(34));
    checkHandshake("len34");

    // Back-pressure: hdr_ready low for 20 cycles after hdr_valid
    buildFrame(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 8'h06, 32'h01020304, 32'h05060708);
    hdr_ready = 1'b0;
    applyStimulus(FA'(64), lat);
    checkOutput("stall_latency", 64'(lat), 64'd14);
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk);
      #1;
      if (!(hdr_valid && !flush && dst_mac == 48'hDEADBEEF0001 && src_mac == 48'hCAFEF00D0002 &&
            ethertype == 16'h0800 && is_ipv4 && ip_proto == 8'h06 && src_ip == 32'h01020304 &&
            dst_ip == 32'h05060708 && frame_len == FA'(64)))
        stable_ok = 1'b0;
    end
    checkOutput("stall_stable", 64'(stable_ok), 64'd1);
    hdr_ready = 1'b1;
    checkHandshake("stall");

    // Runt frame
    fl0 = fl_cnt;
    hv0 = hv_cnt;
    runRunt();
    repeat (5) @(posedge aclk);
    #1;
    checkOutput("runt_drop_count", 64'(drop_count), 64'd1);
    checkOutput("runt_flush_count", 64'(fl_cnt - fl0), 64'd1);
    checkOutput("runt_no_valid", 64'(hv_cnt - hv0), 64'd0);

    // Reset during RD_CAPTURE of offset 8, fifo_ready held high throughout
    buildFrame(48'h112233445566, 48'h778899AABBCC, 16'h0800, 8'h2F, 32'h0B0B0B0B, 32'h0C0C0C0C);
    @(negedge aclk);
    fifo_data_len = FA'(50);
    fifo_ready    = 1'b1;
    fl0 = fl_cnt;
    hv0 = hv_cnt;
    @(posedge aclk);
    repeat (5) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("abort_read_ptr", 64'(read_ptr), 64'd0);
    checkOutput("abort_flush", 64'(flush), 64'd0);
    checkOutput("abort_hdr_valid", 64'(hdr_valid), 64'd0);
    checkOutput("abort_drop_count", 64'(drop_count), 64'd0);
    checkHeader(48'h0, 48'h0, 16'h0, 1'b0, 8'h0, 32'h0, 32'h0, FA'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;
    fifo_ready = 1'b0;
    checkOutput("abort_no_flush", 64'(fl_cnt - fl0), 64'd0);
    checkOutput("abort_restart_ptr", 64'(read_ptr), 64'd0);
    waitValid(lat);
    checkOutput("abort_restart_latency", 64'(lat), 64'd14);
    checkHeader(48'h112233445566, 48'h778899AABBCC, 16'h0800, 1'b1, 8'h2F,
                32'h0B0B0B0B, 32'h0C0C0C0C, FA'(50));
    checkOutput("abort_single_valid_run", 64'(hv_cnt - hv0), 64'd0);
    checkHandshake("abort");

    // Saturation: preload the counter near the top instead of 65535 real runts
    @(negedge aclk);
    force dut.drop_count_q = 16'hFFFE;
    @(negedge aclk);
    release dut.drop_count_q;
    runRunt();
    checkOutput("sat_reach_max", 64'(drop_count), 64'hFFFF);
    runRunt();
    checkOutput("sat_hold_max", 64'(drop_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
